// File: rtl/fw_log_capture.sv
// Non-intrusive firmware log capture. It snoops SRAM writes into a window of
// NUM_CH log addresses and timestamps each hit. Hits are queued in a FWFT FIFO
// and drained over a valid/ready stream.
module fw_log_capture #(
  parameter int unsigned           ADDR_WIDTH = 14,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           NUM_CH     = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 14'h4,
  parameter int unsigned           FIFO_DEPTH = 16,
  parameter int unsigned           TS_WIDTH   = 32,
  parameter int unsigned           CNT_WIDTH  = 16
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [ADDR_WIDTH-1:0]                         sram_address,
  input  logic [DATA_WIDTH-1:0]                         sram_data_in,
  input  logic                                          sram_enable,
  input  logic                                          sram_write,
  input  logic                                          cfg_enable,
  input  logic [NUM_CH-1:0]                             cfg_ch_mask,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [DATA_WIDTH-1:0]                         out_data,
  output logic [TS_WIDTH-1:0]                           out_ts,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] out_ch,
  output logic                                          out_lost,
  output logic [$clog2(FIFO_DEPTH):0]                   fifo_level,
  output logic [CNT_WIDTH-1:0]                          log_count,
  output logic [CNT_WIDTH-1:0]                          drop_count
);

  localparam int unsigned CH_WIDTH  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned PTR_WIDTH = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_WIDTH = PTR_WIDTH + 1;
  localparam int unsigned OFF_WIDTH = ADDR_WIDTH + 1;

  typedef struct packed {
    logic                  lost;
    logic [CH_WIDTH-1:0]   ch;
    logic [TS_WIDTH-1:0]   ts;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  logic [TS_WIDTH-1:0]   ts;
  logic [OFF_WIDTH-1:0]  offset_c;
  logic [CH_WIDTH-1:0]   ch_c;
  logic                  in_window_c;
  logic                  hit_c;

  logic                  cap_valid;
  logic [DATA_WIDTH-1:0] cap_data;
  logic [TS_WIDTH-1:0]   cap_ts;
  logic [CH_WIDTH-1:0]   cap_ch;

  entry_t                mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic                  lost_flag;
  logic [LVL_WIDTH-1:0]  level_next_c;
  logic                  full_c;
  logic                  pop_c;
  logic                  push_c;
  logic                  drop_c;
  entry_t                push_entry_c;
  entry_t                head_c;

  // Hit detection: the window offset is computed one bit wider so addresses below BASE_ADDR wrap high and miss.
  always_comb begin
    offset_c    = {1'b0, sram_address} - {1'b0, BASE_ADDR};
    in_window_c = offset_c < OFF_WIDTH'(NUM_CH);
    ch_c        = offset_c[CH_WIDTH-1:0];
    hit_c       = ~sram_enable & ~sram_write & cfg_enable & in_window_c & cfg_ch_mask[ch_c];
  end

  // FIFO control: a full FIFO still accepts when the head leaves at the same edge.
  always_comb begin
    full_c       = fifo_level == LVL_WIDTH'(FIFO_DEPTH);
    pop_c        = out_valid & out_ready;
    push_c       = cap_valid & (~full_c | pop_c);
    drop_c       = cap_valid & full_c & ~pop_c;
    push_entry_c = '{lost: lost_flag, ch: cap_ch, ts: cap_ts, data: cap_data};
    head_c       = mem[rd_ptr];
    level_next_c = fifo_level;
    if (push_c && !pop_c) begin
      level_next_c = fifo_level + LVL_WIDTH'(1);
    end else if (pop_c && !push_c) begin
      level_next_c = fifo_level - LVL_WIDTH'(1);
    end
  end

  // Head entry is presented only while valid, so an empty FIFO shows zeros.
  always_comb begin
    out_data = out_valid ? head_c.data : '0;
    out_ts   = out_valid ? head_c.ts   : '0;
    out_ch   = out_valid ? head_c.ch   : '0;
    out_lost = out_valid ? head_c.lost : 1'b0;
  end

  // Free-running timestamp, wraps silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts <= '0;
    end else begin
      ts <= ts + TS_WIDTH'(1);
    end
  end

  // One-entry capture stage; a non-hit cycle empties it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_valid <= 1'b0;
      cap_data  <= '0;
      cap_ts    <= '0;
      cap_ch    <= '0;
    end else begin
      cap_valid <= hit_c;
      if (hit_c) begin
        cap_data <= sram_data_in;
        cap_ts   <= ts;
        cap_ch   <= ch_c;
      end
    end
  end

  // FIFO storage; contents are don't-care once the pointers are reset.
  always_ff @(posedge clk) begin
    if (!rst && push_c) begin
      mem[wr_ptr] <= push_entry_c;
    end
  end

  // Pointers, occupancy, lost flag and saturating statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      out_valid  <= 1'b0;
      lost_flag  <= 1'b0;
      log_count  <= '0;
      drop_count <= '0;
    end else begin
      fifo_level <= level_next_c;
      out_valid  <= level_next_c != '0;
      if (push_c) begin
        wr_ptr    <= wr_ptr + PTR_WIDTH'(1);
        lost_flag <= 1'b0;
        if (log_count != '1) begin
          log_count <= log_count + CNT_WIDTH'(1);
        end
      end else if (drop_c) begin
        lost_flag <= 1'b1;
        if (drop_count != '1) begin
          drop_count <= drop_count + CNT_WIDTH'(1);
        end
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fw_log_capture.sv
// Self-checking bench for fw_log_capture: queue-based reference model checked
// every cycle, a vector table for hit filtering, and directed corner sequences.
module tb_fw_log_capture;

  localparam logic [13:0] BASE  = 14'h4;
  localparam int          NCH   = 4;
  localparam int          DEPTH = 16;
  localparam int          CMAX  = 65535;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] sram_address;
  logic [31:0] sram_data_in;
  logic        sram_enable;
  logic        sram_write;
  logic        cfg_enable;
  logic [3:0]  cfg_ch_mask;
  logic        out_ready;

  logic        out_valid, out_lost;
  logic [31:0] out_data, out_ts;
  logic [1:0]  out_ch;
  logic [4:0]  fifo_level;
  logic [15:0] log_count, drop_count;

  logic        o8_valid, o8_lost;
  logic [31:0] o8_data;
  logic [7:0]  o8_ts;
  logic [1:0]  o8_ch;
  logic [4:0]  o8_level;
  logic [15:0] o8_log, o8_drop;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fw_log_capture dut (
    .clk(clk), .rst(rst), .sram_address(sram_address), .sram_data_in(sram_data_in),
    .sram_enable(sram_enable), .sram_write(sram_write), .cfg_enable(cfg_enable),
    .cfg_ch_mask(cfg_ch_mask), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ts(out_ts), .out_ch(out_ch), .out_lost(out_lost),
    .fifo_level(fifo_level), .log_count(log_count), .drop_count(drop_count)
  );

  fw_log_capture #(.TS_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .sram_address(sram_address), .sram_data_in(sram_data_in),
    .sram_enable(sram_enable), .sram_write(sram_write), .cfg_enable(cfg_enable),
    .cfg_ch_mask(cfg_ch_mask), .out_valid(o8_valid), .out_ready(out_ready),
    .out_data(o8_data), .out_ts(o8_ts), .out_ch(o8_ch), .out_lost(o8_lost),
    .fifo_level(o8_level), .log_count(o8_log), .drop_count(o8_drop)
  );

  // Reference model state
  typedef struct packed {
    logic [31:0] data;
    logic [31:0] ts;
    logic [1:0]  ch;
    logic        lost;
  } ent_t;

  ent_t        q[$];
  ent_t        cap;
  bit          cap_v;
  bit          m_lost;
  logic [31:0] m_ts;
  int          m_log;
  int          m_drop;

  typedef struct {
    logic [13:0] addr;
    logic        wr_n;
    logic        en_n;
    logic        cfg_en;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        exp_valid;
    logic [1:0]  exp_ch;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the spec's rules for one clock edge using the inputs currently driven.
  task automatic model_edge();
    int   off;
    bit   pop;
    bit   full;
    bit   hit;
    ent_t e;
    if (rst) begin
      q.delete();
      cap_v  = 0;
      m_lost = 0;
      m_ts   = '0;
      m_log  = 0;
      m_drop = 0;
      return;
    end
    pop  = (q.size() != 0) && out_ready;
    full = (q.size() == DEPTH);
    if (pop) void'(q.pop_front());
    if (cap_v) begin
      if (!full || pop) begin
        e      = cap;
        e.lost = m_lost;
        q.push_back(e);
        m_lost = 0;
        if (m_log < CMAX) m_log++;
      end else begin
        m_lost = 1;
        if (m_drop < CMAX) m_drop++;
      end
    end
    off = int'(sram_address) - int'(BASE);
    hit = !sram_enable && !sram_write && cfg_enable && off >= 0 && off < NCH && cfg_ch_mask[off];
    cap_v = hit;
    if (hit) begin
      cap.data = sram_data_in;
      cap.ts   = m_ts;
      cap.ch   = 2'(off);
      cap.lost = 1'b0;
    end
    m_ts = m_ts + 32'd1;
  endtask

  task automatic check_model();
    ent_t h;
    chk("valid", 64'(out_valid), 64'(q.size() != 0));
    chk("level", 64'(fifo_level), 64'(q.size()));
    chk("log_count", 64'(log_count), 64'(m_log));
    chk("drop_count", 64'(drop_count), 64'(m_drop));
    chk("ts8_valid", 64'(o8_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      h = q[0];
      chk("data", 64'(out_data), 64'(h.data));
      chk("ts", 64'(out_ts), 64'(h.ts));
      chk("ch", 64'(out_ch), 64'(h.ch));
      chk("lost", 64'(out_lost), 64'(h.lost));
      chk("ts8_data", 64'(o8_data), 64'(h.data));
      chk("ts8_ts", 64'(o8_ts), 64'(h.ts[7:0]));
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic idle_inputs();
    sram_enable  = 1'b1;
    sram_write   = 1'b1;
    sram_address = '0;
    sram_data_in = '0;
  endtask

  task automatic drive_write(input logic [13:0] a, input logic [31:0] d);
    sram_enable  = 1'b0;
    sram_write   = 1'b0;
    sram_address = a;
    sram_data_in = d;
  endtask

  task automatic do_reset();
    idle_inputs();
    out_ready   = 1'b0;
    rst         = 1'b1;
    step();
    rst         = 1'b0;
    cfg_enable  = 1'b1;
    cfg_ch_mask = 4'hF;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          exp_log;
    logic [31:0] exp_seq[17];

    vecs[0] = '{BASE,         1'b1, 1'b0, 1'b1, 4'hF, 32'h11, 1'b0, 2'd0};
    vecs[1] = '{BASE + 14'd4, 1'b0, 1'b0, 1'b1, 4'hF, 32'h12, 1'b0, 2'd0};
    vecs[2] = '{BASE - 14'd1, 1'b0, 1'b0, 1'b1, 4'hF, 32'h13, 1'b0, 2'd0};
    vecs[3] = '{BASE + 14'd1, 1'b0, 1'b0, 1'b1, 4'hD, 32'h14, 1'b0, 2'd0};
    vecs[4] = '{BASE + 14'd1, 1'b0, 1'b1, 1'b1, 4'hF, 32'h15, 1'b0, 2'd0};
    vecs[5] = '{BASE,         1'b0, 1'b0, 1'b0, 4'hF, 32'h16, 1'b0, 2'd0};
    vecs[6] = '{14'h3FFF,     1'b0, 1'b0, 1'b1, 4'hF, 32'h17, 1'b0, 2'd0};
    vecs[7] = '{14'h0000,     1'b0, 1'b0, 1'b1, 4'hF, 32'h18, 1'b0, 2'd0};
    vecs[8] = '{BASE,         1'b0, 1'b0, 1'b1, 4'hF, 32'h19, 1'b1, 2'd0};
    vecs[9] = '{BASE + 14'd3, 1'b0, 1'b0, 1'b1, 4'h8, 32'h1A, 1'b1, 2'd3};

    cfg_enable  = 1'b1;
    cfg_ch_mask = 4'hF;
    do_reset();

    // Reset values
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_ts", 64'(out_ts), 64'd0);
    chk("rst_ch", 64'(out_ch), 64'd0);
    chk("rst_lost", 64'(out_lost), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);

    // Single write at ts=10, two-cycle latency
    out_ready = 1'b1;
    repeat (10) step();
    drive_write(BASE + 14'd2, 32'hDEADBEEF);
    step();
    idle_inputs();
    chk("lat_cap_valid", 64'(out_valid), 64'd0);
    step();
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_data", 64'(out_data), 64'hDEADBEEF);
    chk("single_ts", 64'(out_ts), 64'd10);
    chk("single_ch", 64'(out_ch), 64'd2);
    chk("single_lost", 64'(out_lost), 64'd0);
    chk("single_log", 64'(log_count), 64'd1);
    step();
    step();

    // Hit filtering table
    do_reset();
    out_ready = 1'b1;
    exp_log   = 0;
    for (int i = 0; i < 10; i++) begin
      sram_address = vecs[i].addr;
      sram_write   = vecs[i].wr_n;
      sram_enable  = vecs[i].en_n;
      sram_data_in = vecs[i].data;
      cfg_enable   = vecs[i].cfg_en;
      cfg_ch_mask  = vecs[i].mask;
      step();
      idle_inputs();
      cfg_enable  = 1'b1;
      cfg_ch_mask = 4'hF;
      step();
      chk("tbl_valid", 64'(out_valid), 64'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        exp_log++;
        chk("tbl_data", 64'(out_data), 64'(vecs[i].data));
        chk("tbl_ch", 64'(out_ch), 64'(vecs[i].exp_ch));
      end
      chk("tbl_log", 64'(log_count), 64'(exp_log));
      step();
    end

    // Overflow, lost flag on the first accepted entry after drops
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      drive_write(BASE, 32'(i));
      step();
    end
    idle_inputs();
    step();
    step();
    chk("ovf_level", 64'(fifo_level), 64'd16);
    chk("ovf_drop", 64'(drop_count), 64'd4);
    chk("ovf_log", 64'(log_count), 64'd16);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    drive_write(BASE, 32'd21);
    step();
    idle_inputs();
    step();
    chk("ovf_refill_level", 64'(fifo_level), 64'd16);
    for (int k = 0; k < 15; k++) exp_seq[k] = 32'(k + 2);
    exp_seq[15] = 32'd21;
    exp_seq[16] = 32'd22;
    out_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      chk("ovf_order", 64'(out_data), 64'(exp_seq[k]));
      chk("ovf_lost", 64'(out_lost), 64'(exp_seq[k] == 32'd21));
      if (k == 0) drive_write(BASE, 32'd22);
      else idle_inputs();
      step();
    end
    chk("ovf_empty", 64'(out_valid), 64'd0);

    // Full FIFO with a pop at every edge keeps accepting
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      drive_write(BASE + 14'(i % NCH), 32'(i));
      step();
    end
    idle_inputs();
    step();
    step();
    for (int j = 0; j < 32; j++) begin
      drive_write(BASE + 14'(j % NCH), 32'(17 + j));
      out_ready = (j != 0);
      step();
      chk("full_pop_level", 64'(fifo_level), 64'd16);
      chk("full_pop_drop", 64'(drop_count), 64'd0);
      chk("full_pop_order", 64'(out_data), 64'(j + 1));
    end
    idle_inputs();
    out_ready = 1'b1;
    repeat (20) step();

    // Random traffic with random backpressure
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        sram_enable  = 1'b0;
        sram_write   = ($urandom_range(0, 7) == 0);
        sram_address = 14'(int'(BASE) - 1 + int'($urandom_range(0, 5)));
      end else begin
        idle_inputs();
      end
      sram_data_in = $urandom;
      cfg_ch_mask  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      cfg_enable   = ($urandom_range(0, 15) != 0);
      out_ready    = 1'($urandom_range(0, 1));
      step();
    end
    idle_inputs();
    cfg_enable  = 1'b1;
    cfg_ch_mask = 4'hF;
    out_ready   = 1'b1;
    repeat (20) step();
    chk("rand_drained", 64'(out_valid), 64'd0);

    // Reset mid-stream drops queued and in-flight entries
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_write(BASE + 14'd1, 32'h100 + 32'(i));
      step();
    end
    idle_inputs();
    step();
    step();
    chk("mid_level", 64'(fifo_level), 64'd5);
    drive_write(BASE, 32'hBAD);
    step();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data", 64'(out_data), 64'd0);
    chk("mid_rst_ts", 64'(out_ts), 64'd0);
    chk("mid_rst_ch", 64'(out_ch), 64'd0);
    chk("mid_rst_lost", 64'(out_lost), 64'd0);
    chk("mid_rst_level", 64'(fifo_level), 64'd0);
    chk("mid_rst_log", 64'(log_count), 64'd0);
    chk("mid_rst_drop", 64'(drop_count), 64'd0);
    drive_write(BASE + 14'd1, 32'h600D);
    step();
    idle_inputs();
    step();
    chk("post_rst_data", 64'(out_data), 64'h600D);
    chk("post_rst_ts", 64'(out_ts), 64'd0);
    chk("post_rst_level", 64'(fifo_level), 64'd1);
    out_ready = 1'b1;
    repeat (4) step();
    chk("post_rst_no_ghost", 64'(out_valid), 64'd0);

    // Timestamp wrap on the 8-bit instance
    do_reset();
    out_ready = 1'b1;
    repeat (255) step();
    drive_write(BASE, 32'hA5);
    step();
    drive_write(BASE + 14'd3, 32'h5A);
    step();
    idle_inputs();
    chk("wrap_ts8_255", 64'(o8_ts), 64'hFF);
    chk("wrap_ts32_255", 64'(out_ts), 64'd255);
    step();
    chk("wrap_ts8_0", 64'(o8_ts), 64'h00);
    chk("wrap_ts32_256", 64'(out_ts), 64'd256);
    chk("wrap_ch", 64'(o8_ch), 64'd3);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fw_log_capture.md
Name: fw_log_capture

Overview:
Synthesizable multi-channel successor to the firmware log monitor. It snoops an SRAM write port for writes into a window of NUM_CH consecutive log addresses, and timestamps each hit with a free-running cycle counter. Hits are buffered in an on-chip FIFO and drained over a valid/ready stream to a trace DMA or debug port. The block is non-intrusive: it is input-only on the SRAM side and never stalls the SRAM.

Parameters:
- ADDR_WIDTH, 14, SRAM address width.
- DATA_WIDTH, 32, SRAM data width.
- NUM_CH, 4, number of log channels (1..16); channel k sits at BASE_ADDR+k.
- BASE_ADDR, 14'h4, address of channel 0; BASE_ADDR+NUM_CH-1 must not exceed 2^ADDR_WIDTH-1.
- FIFO_DEPTH, 16, entry count, power of two, at least 2.
- TS_WIDTH, 32, timestamp counter width.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- sram_address  in  ADDR_WIDTH  SRAM address.
- sram_data_in  in  DATA_WIDTH  SRAM write data.
- sram_enable  in  1  SRAM chip enable, active low.
- sram_write  in  1  SRAM write strobe, active low.
- cfg_enable  in  1  global capture enable.
- cfg_ch_mask  in  NUM_CH  per-channel capture enable; bit k corresponds to channel k.
- out_valid  out  1  FIFO head entry is valid.
- out_ready  in  1  consumer accepts the head entry.
- out_data  out  DATA_WIDTH  logged data.
- out_ts  out  TS_WIDTH  timestamp at the capture edge.
- out_ch  out  max(1,$clog2(NUM_CH))  channel index.
- out_lost  out  1  one or more entries were dropped immediately before this one.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- log_count  out  CNT_WIDTH  entries accepted into the FIFO; saturating.
- drop_count  out  CNT_WIDTH  entries dropped due to a full FIFO; saturating.

Behaviour:
- Reset: all outputs are 0. This covers out_valid, out_data, out_ts, out_ch, out_lost, fifo_level, log_count and drop_count. Reset also clears the timestamp counter, the FIFO pointers, the capture stage and the lost flag.
- Reset mid-operation: any FIFO contents and in-flight capture are discarded. There is no partial output.
- Timestamp ts: ts = 0 in the first cycle after reset is released. It increments by 1 every clk edge and wraps modulo 2^TS_WIDTH without any flag.
- Hit condition, evaluated at a posedge: !sram_enable && !sram_write && cfg_enable && in-window && cfg_ch_mask[ch].
  - in-window: (sram_address - BASE_ADDR), computed in ADDR_WIDTH+1 bits, is unsigned and < NUM_CH.
  - ch = sram_address - BASE_ADDR.
- Capture stage (S0 to S1): a hit at edge N registers {data, ts-at-edge-N, ch} into a one-entry capture register with cap_valid=1. A non-hit clears cap_valid. The capture register accepts back-to-back hits every cycle.
- FIFO write at edge N+1 when cap_valid=1. There are three cases:
  - FIFO not full: push the entry with lost=lost_flag, clear lost_flag, and increment log_count.
  - FIFO full and (out_valid && out_ready) at the same edge: pop and push both succeed and are counted as an accept. The level is unchanged.
  - FIFO full with no pop: drop the entry, set lost_flag=1, and increment drop_count. The level is unchanged.
- Output stream is first-word-fall-through:
  - out_valid = (fifo_level != 0).
  - out_* present the head entry.
  - A hit at edge N appears on out_valid in the cycle following edge N+1, which is 2-cycle latency.
  - A pop occurs at an edge where out_valid && out_ready.
  - out_* must hold stable while out_valid && !out_ready.
- Simultaneous push and pop when not full or not empty: the level is unchanged. An empty FIFO with a push has out_valid=0 that cycle; no bypass is allowed.
- Counters saturate at 2^CNT_WIDTH-1 and do not wrap.
- Ordering: entries leave in capture order regardless of channel.
- cfg_enable or cfg_ch_mask deasserting only blocks new hits. The capture stage and the FIFO still complete and drain.
- Writes with X/Z on sram_data_in are captured as-is. There is no filtering.

Test Plan:
- Single write: BASE_ADDR+2 with data 0xDEADBEEF at ts=10, out_ready=1 → out_valid high 2 cycles later with out_data=0xDEADBEEF, out_ts=10, out_ch=2, out_lost=0, log_count=1.
- Non-hits filtered: a read (sram_write=1) at BASE_ADDR, a write to BASE_ADDR+NUM_CH, a write to BASE_ADDR-1, and a write with cfg_ch_mask[1]=0 to channel 1 → no entries, log_count=0.
- Overflow: out_ready=0 and 20 back-to-back hits with data 1..20 → fifo_level=16, drop_count=4. Then a hit with data 21 after draining one entry → after popping data 1..16, the next entry has data=21 and out_lost=1, and the following entries have out_lost=0.
- Full with concurrent pop: FIFO full, out_ready=1 every cycle, hits every cycle for 32 cycles → drop_count=0, fifo_level stays 16, and output order is strictly the capture order.
- Backpressure hold: out_ready toggles 0/1 at random → out_* remain stable while out_valid && !out_ready, and no entry is lost or duplicated compared with a scoreboard.
- Reset mid-stream: FIFO holding 5 entries and a hit in flight, assert rst for 1 cycle → all outputs are 0 the next cycle, and the in-flight hit never appears. ts restarts at 0, and a timestamp wrap at TS_WIDTH=8 rolls from 255 to 0.
